uart_tx_feeder: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_sync_fifo.sv | 65 ++++++
 rtl/uart_tx_feeder.sv | 132 +++++++++++++
 tb/tb_uart_tx_feeder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: feeder FSM encoding, byte type and timing constants.
// ST_GAP exists only when UART_TX_FEEDER_GAP_EN is defined.
package uart_pkg;

  typedef logic [7:0] byte_t;

  localparam int WAIT_HI_TIMEOUT = 8;
  localparam int TMO_W = $clog2(WAIT_HI_TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_HI,
`ifdef UART_TX_FEEDER_GAP_EN
    ST_WAIT_LO,
    ST_GAP
`else
    ST_WAIT_LO
`endif
  } state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with combinational head; shared by TX and RX paths.
// Full is judged before any same-cycle pop, so a write while full is dropped.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  byte_t         wr_data,
  input  logic          rd_en,
  output byte_t         rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  byte_t         mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr_ok, rd_ok;

  assign full    = (cnt_q == FULL_LVL);
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign rd_data = mem_q[rptr_q];

  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr_ok) wptr_d = wptr_q + 1'b1;
    if (rd_ok) rptr_d = rptr_q + 1'b1;
    unique case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers application bytes and hands them one by one to the UART transmitter.
// Define UART_TX_FEEDER_GAP_EN to add gap_cycles and an inter-byte GAP state.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
`ifdef UART_TX_FEEDER_GAP_EN
  input  logic [15:0]   gap_cycles,
`endif
  input  logic          wr_en,
  input  byte_t         wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  input  logic          ovf_clr,
  output byte_t         tx_data,
  output logic          tx_start,
  input  logic          tx_busy,
  output logic          idle
);

  state_t             state_q;
  byte_t              tx_data_q;
  logic               tx_start_q;
  logic [TMO_W-1:0]   tmo_q;
  logic               ovf_q, ovf_d;
  logic               fifo_full, fifo_empty, rd_en;
  byte_t              head;
`ifdef UART_TX_FEEDER_GAP_EN
  logic [15:0]        gap_q;
`endif

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign full     = fifo_full;
  assign empty    = fifo_empty;
  assign overflow = ovf_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign rd_en    = (state_q == ST_IDLE) && !fifo_empty;
  assign idle     = (state_q == ST_IDLE) && fifo_empty;

  // A new overflow event outranks a clear arriving in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && fifo_full) ovf_d = 1'b1;
    else if (ovf_clr)       ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      tmo_q      <= '0;
`ifdef UART_TX_FEEDER_GAP_EN
      gap_q      <= '0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            tx_data_q  <= head;
            tx_start_q <= 1'b1;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          tmo_q   <= '0;
          state_q <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (tx_busy) begin
            state_q <= ST_WAIT_LO;
          end else if (tmo_q == TMO_W'(WAIT_HI_TIMEOUT - 1)) begin
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_WAIT_LO: begin
          if (!tx_busy) begin
`ifdef UART_TX_FEEDER_GAP_EN
            gap_q   <= gap_cycles;
            state_q <= ST_GAP;
`else
            state_q <= ST_IDLE;
`endif
          end
        end
`ifdef UART_TX_FEEDER_GAP_EN
        ST_GAP: begin
          if (gap_q <= 16'd1) begin
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized bench for uart_tx_feeder against an event-level hand-off model.
// Honours UART_TX_FEEDER_GAP_EN when defined.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          tx_busy = 1'b0;
  logic [7:0]    wr_data = '0;
  logic [7:0]    tx_data;
  logic          full, empty, overflow, tx_start, idle;
  logic [AW:0]   level;
`ifdef UART_TX_FEEDER_GAP_EN
  logic [15:0]   gap_cycles = '0;
`endif

  int n_chk = 0;
  int n_err = 0;

  // model state: queue contents, last handed byte, and hand-off timing plan
  logic [7:0] q[$];
  int         arr[$];
  logic [7:0] cur;
  bit         ovf_m, st_m;
  int         c, free_at, bon, boff, gap_g;
  int         force_d, force_l;
  bit         force_tmo, rand_tmo;

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef UART_TX_FEEDER_GAP_EN
    .gap_cycles (gap_cycles),
`endif
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .idle       (idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int gap_extra();
`ifdef UART_TX_FEEDER_GAP_EN
    return (gap_g < 1) ? 1 : gap_g;
`else
    return 0;
`endif
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_full"},     32'(full),     32'd0);
    chk({tag, "_empty"},    32'(empty),    32'd1);
    chk({tag, "_level"},    32'(level),    32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_tx_data"},  32'(tx_data),  32'd0);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_idle"},     32'(idle),     32'd1);
  endtask

  // One clock: drive at negedge, predict at posedge, check at next negedge.
  task automatic cyc(input bit w, input logic [7:0] d, input bit clr);
    bit pop, tmo;
    int dd, ll, n;
    wr_en   = w;
    wr_data = d;
    ovf_clr = clr;
    tx_busy = (c >= bon) && (c < boff);
    @(posedge clk);
    c++;
    n    = q.size();
    pop  = (n > 0) && (c >= free_at) && (arr[0] < c);
    st_m = 1'b0;
    if (w && n == DEPTH) ovf_m = 1'b1;
    else if (clr)        ovf_m = 1'b0;
    if (pop) begin
      cur  = q.pop_front();
      void'(arr.pop_front());
      st_m = 1'b1;
      tmo  = force_tmo || (rand_tmo && $urandom_range(0, 5) == 0);
      if (tmo) begin
        bon     = 0;
        boff    = 0;
        free_at = c + 10;
      end else begin
        dd      = (force_d > 0) ? force_d : int'($urandom_range(1, 3));
        ll      = (force_l > 0) ? force_l : int'($urandom_range(1, 6));
        bon     = c + dd;
        boff    = c + dd + ll;
        free_at = boff + 2 + gap_extra();
      end
    end
    if (w && n < DEPTH) begin
      q.push_back(d);
      arr.push_back(c);
    end
    @(negedge clk);
    chk("tx_start", 32'(tx_start), 32'(st_m));
    chk("tx_data",  32'(tx_data),  32'(cur));
    chk("level",    32'(level),    32'(q.size()));
    chk("full",     32'(full),     32'(q.size() == DEPTH));
    chk("empty",    32'(empty),    32'(q.size() == 0));
    chk("overflow", 32'(overflow), 32'(ovf_m));
    chk("idle",     32'(idle),     32'((c >= free_at - 1) && q.size() == 0));
  endtask

  task automatic drain();
    for (int k = 0; k < 3000 && !(q.size() == 0 && c >= free_at); k++)
      cyc(1'b0, 8'h00, 1'b0);
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    c = 0; free_at = 0; bon = 0; boff = 0; gap_g = 0;
    cur = '0; ovf_m = 1'b0; st_m = 1'b0;
    force_d = 0; force_l = 0; force_tmo = 1'b0; rand_tmo = 1'b0;

    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b0;
    repeat (3) cyc(1'b0, 8'h00, 1'b0);

    // single byte, long frame
    force_d = 1; force_l = 100;
    cyc(1'b1, 8'hA5, 1'b0);
    drain();
    force_d = 0; force_l = 0;

    // burst ordering
    for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(i), 1'b0);
    drain();

    // fill, overflow, clear precedence, write-while-full during a pop
    force_d = 1; force_l = 30;
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b1, 8'($urandom), 1'b0);
    chk("full_level", 32'(level), 32'(DEPTH));
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'hEE, 1'b0);
    cyc(1'b1, 8'hEF, 1'b1);
    force_l = 0;
    for (int i = 0; i < 30; i++) cyc(1'b1, 8'($urandom), 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    drain();

    // WAIT_HI timeout, then a normal byte
    force_tmo = 1'b1;
    cyc(1'b1, 8'h3C, 1'b0);
    repeat (4) cyc(1'b0, 8'h00, 1'b0);
    force_tmo = 1'b0;
    cyc(1'b1, 8'h77, 1'b0);
    drain();

    // random traffic
    rand_tmo = 1'b1;
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 7) == 0);
    rand_tmo = 1'b0;
    drain();

    // reset in the middle of a frame
    force_d = 1; force_l = 20; bon = 0; boff = 0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
    for (int k = 0; k < 100 && !(bon > 0 && c == bon + 2); k++)
      cyc(1'b0, 8'h00, 1'b0);
    chk("mid_frame_reached", 32'(bon > 0 && c == bon + 2), 32'd1);
    wr_en = 1'b0; ovf_clr = 1'b0;
    #2 rst = 1'b1;
    tx_busy = 1'b0;
    #1 chk_reset_vals("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("midrst_hold");
    rst = 1'b0;
    q.delete(); arr.delete();
    cur = '0; ovf_m = 1'b0; bon = 0; boff = 0; free_at = c;
    force_d = 0; force_l = 0;
    repeat (10) cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'h5A, 1'b0);
    drain();

`ifdef UART_TX_FEEDER_GAP_EN
    gap_g = 10; gap_cycles = 16'd10;
    force_d = 1; force_l = 5;
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    drain();
    force_d = 0; force_l = 0;
    for (int i = 0; i < 200; i++)
      cyc($urandom_range(0, 3) == 0, 8'($urandom), 1'b0);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
